// File: rtl/spi_pkg.sv
// Shared types and constants for the 3-wire SPI master byte engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    // Bits per byte phase; fixed at 8 for this release.
    localparam int DATA_W = 8;
    localparam int BIT_W  = $clog2(DATA_W);

    // Width of the half-period divider counter (CLK_DIV legal range 1..255).
    localparam int DIV_W  = 8;

    // Direction control toward the tristate cell.
    localparam logic CTRL_DRIVE   = 1'b1;
    localparam logic CTRL_RELEASE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TX_CMD,
        TX_DATA,
        TURN,
        RX_DATA,
        HOLD,
        DONE
    } state_e;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period divider: pulses tick_o on the last of every CLK_DIV enabled clocks.
// Latency: first tick CLK_DIV clocks after enable rises from a cleared count.
// Backpressure: none; clr_i has priority over en_i and zeroes the count.
// Ports: clk, rst_n (async active-low), en_i (count), clr_i (sync clear), tick_o.
module spi_half_tick
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi3w_master_shifter.sv
// Half-duplex 3-wire SPI master: command byte then one write byte or one read byte, LSB first, mode 0.
// Latency: done in cycle k+34*CLK_DIV+1 (write) / k+35*CLK_DIV+1 (read) after start is accepted on edge k.
// Backpressure: start is only sampled in IDLE; busy is high from the cycle after acceptance through DONE.
// Ports: clk, rst_n, start/rw/cmd_data/wr_data (request), busy/done/rx_data (status),
//        sclk/cs_n (to slave), outline/control (to tristate cell), inline (from tristate cell).
module spi3w_master_shifter
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rw,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs_n,
    output logic              outline,
    output logic              control,
    input  logic              inline
);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic              phase_q, phase_d;    // 0 = low half of a bit, 1 = high half
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wr_q, wr_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    logic cs_n_q, cs_n_d;
    logic sclk_q, sclk_d;
    logic control_q, control_d;
    logic outline_q, outline_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic tick;
    logic div_en;
    logic div_clr;

    // The divider runs only while the bus is owned; it restarts from zero on every transaction.
    assign div_clr = (state_q == IDLE);
    assign div_en  = (state_q != IDLE) && (state_q != DONE);

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (div_en),
        .clr_i  (div_clr),
        .tick_o (tick)
    );

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        rw_d      = rw_q;
        wr_d      = wr_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    rw_d    = rw;
                    wr_d    = wr_data;
                    tx_sr_d = cmd_data;
                    rx_sr_d = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = TX_CMD;
                end
            end
            TX_CMD, TX_DATA, RX_DATA: begin
                if (tick) begin
                    if (!phase_q) begin
                        // End of low half: sclk rises here, so this is the sample point.
                        phase_d = 1'b1;
                        if (state_q == RX_DATA) begin
                            rx_sr_d[bit_q] = inline;
                        end
                    end else begin
                        // End of high half: sclk falls and the next bit is presented.
                        phase_d = 1'b0;
                        bit_d   = bit_q + BIT_W'(1);
                        tx_sr_d = tx_sr_q >> 1;
                        if (bit_q == LAST_BIT) begin
                            bit_d = '0;
                            if (state_q == TX_CMD) begin
                                if (rw_q) begin
                                    state_d = TURN;
                                end else begin
                                    state_d = TX_DATA;
                                    tx_sr_d = wr_q;
                                end
                            end else begin
                                state_d = HOLD;
                            end
                        end
                    end
                end
            end
            TURN: begin
                if (tick) begin
                    state_d = RX_DATA;
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Received byte becomes visible in the DONE cycle of reads only.
        if ((state_d == DONE) && rw_q) begin
            rx_data_d = rx_sr_d;
        end
    end

    // Output decode from next state so every pin comes straight from a flop.
    always_comb begin
        cs_n_d    = (state_d == IDLE) || (state_d == DONE);
        sclk_d    = phase_d && ((state_d == TX_CMD) || (state_d == TX_DATA) ||
                                (state_d == RX_DATA));
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        control_d = CTRL_RELEASE;
        outline_d = 1'b0;

        case (state_d)
            SETUP, TX_CMD, TX_DATA: begin
                control_d = CTRL_DRIVE;
                outline_d = tx_sr_d[0];
            end
            HOLD: begin
                // Keep direction and last bit so a write holds data and a read never re-drives.
                control_d = control_q;
                outline_d = outline_q;
            end
            default: begin
                control_d = CTRL_RELEASE;
                outline_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= 1'b0;
            bit_q     <= '0;
            rw_q      <= 1'b0;
            wr_q      <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            control_q <= CTRL_RELEASE;
            outline_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            rw_q      <= rw_d;
            wr_q      <= wr_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            control_q <= control_d;
            outline_q <= outline_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign outline = outline_q;
    assign control = control_q;

endmodule

// File: tb/tb_spi3w_master_shifter.sv
// Directed bench for spi3w_master_shifter: one instance at CLK_DIV=2, one at CLK_DIV=1.
// A bus monitor and slave model watch whichever instance is selected.
// Summary: passed/total checks.
module tb_spi3w_master_shifter;

    logic       clk;
    logic       rst_n;
    logic       start2, start1;
    logic       rw;
    logic [7:0] cmd_data, wr_data;
    logic       slv_dat;

    logic       busy2, done2, sclk2, cs_n2, outline2, control2;
    logic [7:0] rx2;
    logic       busy1, done1, sclk1, cs_n1, outline1, control1;
    logic [7:0] rx1;

    spi3w_master_shifter #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .rw(rw),
        .cmd_data(cmd_data), .wr_data(wr_data),
        .busy(busy2), .done(done2), .rx_data(rx2),
        .sclk(sclk2), .cs_n(cs_n2), .outline(outline2), .control(control2),
        .inline(slv_dat)
    );

    spi3w_master_shifter #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .rw(rw),
        .cmd_data(cmd_data), .wr_data(wr_data),
        .busy(busy1), .done(done1), .rx_data(rx1),
        .sclk(sclk1), .cs_n(cs_n1), .outline(outline1), .control(control1),
        .inline(slv_dat)
    );

    // Monitor view of the selected instance (0 = CLK_DIV 2, 1 = CLK_DIV 1)
    logic       sel;
    logic       m_busy, m_done, m_sclk, m_cs_n, m_outline, m_control;
    logic [7:0] m_rx;
    assign m_busy    = sel ? busy1    : busy2;
    assign m_done    = sel ? done1    : done2;
    assign m_sclk    = sel ? sclk1    : sclk2;
    assign m_cs_n    = sel ? cs_n1    : cs_n2;
    assign m_outline = sel ? outline1 : outline2;
    assign m_control = sel ? control1 : control2;
    assign m_rx      = sel ? rx1      : rx2;

    int passes = 0;
    int checks = 0;

    // Monitor / slave state
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          ctl1 = 0;
    int          ctl0 = 0;
    int          mon_errs = 0;
    logic [31:0] rise_bits = '0;
    logic        sclk_prev = 1'b0;
    logic        cs_prev = 1'b1;
    logic        slv_drv = 1'b0;
    logic        slv_read = 1'b0;
    logic [7:0]  slv_byte = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor and slave: the slave drives its byte LSB first after the
    // command's 8th falling sclk edge, changing on falling edges, for 8 bits.
    initial begin
        slv_dat = 1'b0;
        forever begin
            @(negedge clk);
            if (m_cs_n) begin
                if (m_sclk !== 1'b0) begin
                    mon_errs++;
                    $display("FAIL sclk_idle: sclk=%b while cs_n=1, required 0 (t=%0t)", m_sclk, $time);
                end
                slv_drv = 1'b0;
            end else begin
                if (cs_prev) begin
                    rise_cnt  = 0;
                    fall_cnt  = 0;
                    ctl1      = 0;
                    ctl0      = 0;
                    rise_bits = '0;
                    sclk_prev = 1'b0;
                end
                if (slv_drv && (m_control !== 1'b0)) begin
                    mon_errs++;
                    $display("FAIL contention: control=%b while slave drives, required 0 (t=%0t)", m_control, $time);
                end
                if (m_control) ctl1++;
                else ctl0++;
                if (m_sclk && !sclk_prev) begin
                    if (rise_cnt < 32) rise_bits[rise_cnt] = m_outline;
                    rise_cnt++;
                end
                if (!m_sclk && sclk_prev) fall_cnt++;
                sclk_prev = m_sclk;
                slv_drv = slv_read && (fall_cnt >= 8) && (fall_cnt < 16);
            end
            cs_prev = m_cs_n;
            if (slv_drv) slv_dat = slv_byte[fall_cnt - 8];
            else         slv_dat = 1'b0;
        end
    end

    // Stimulus helpers (no checking inside)
    task automatic launch(input logic s, input logic r, input logic [7:0] c,
                          input logic [7:0] w, input logic [7:0] sb);
        @(negedge clk);
        sel      = s;
        rw       = r;
        cmd_data = c;
        wr_data  = w;
        slv_read = r;
        slv_byte = sb;
        if (s) start1 = 1'b1;
        else   start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Returns clocks from the accepting edge to the first cycle with done, or -1 on timeout.
    task automatic run_to_done(output int c);
        c = 0;
        while (!m_done && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (!m_done) c = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cs_n2 !== 1'b1)    $display("FAIL reset_cs_n: got %b want 1", cs_n2);    else passes++;
        checks++; if (sclk2 !== 1'b0)    $display("FAIL reset_sclk: got %b want 0", sclk2);    else passes++;
        checks++; if (control2 !== 1'b0) $display("FAIL reset_control: got %b want 0", control2); else passes++;
        checks++; if (outline2 !== 1'b0) $display("FAIL reset_outline: got %b want 0", outline2); else passes++;
        checks++; if ({busy2, done2} !== 2'b00) $display("FAIL reset_busy_done: got %b want 00", {busy2, done2}); else passes++;
        checks++; if (rx2 !== 8'h00)     $display("FAIL reset_rx_data: got %h want 00", rx2);  else passes++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int c;
        launch(1'b0, 1'b0, 8'hA5, 8'h3C, 8'h00);
        checks++; if ({m_busy, m_cs_n} !== 2'b10) $display("FAIL wr_busy_start: busy,cs_n=%b want 10", {m_busy, m_cs_n}); else passes++;
        run_to_done(c);
        checks++; if (c !== 68) $display("FAIL wr_latency: done after %0d clocks want 68", c); else passes++;
        checks++; if (m_rx !== 8'h00) $display("FAIL wr_rx_held: rx_data=%h want 00", m_rx); else passes++;
        repeat (2) @(negedge clk);
        checks++; if (rise_cnt !== 16) $display("FAIL wr_rise_count: %0d want 16", rise_cnt); else passes++;
        checks++; if (rise_bits[15:0] !== 16'h3CA5) $display("FAIL wr_bits: %h want 3ca5", rise_bits[15:0]); else passes++;
        checks++; if (ctl0 !== 0) $display("FAIL wr_control_low: %0d cycles with control=0 want 0", ctl0); else passes++;
        checks++; if ({m_busy, m_cs_n} !== 2'b01) $display("FAIL wr_idle_after: busy,cs_n=%b want 01", {m_busy, m_cs_n}); else passes++;
    endtask

    task automatic test_read();
        int c;
        launch(1'b0, 1'b1, 8'h0F, 8'h00, 8'hAA);
        run_to_done(c);
        checks++; if (c !== 70) $display("FAIL rd_latency: done after %0d clocks want 70", c); else passes++;
        checks++; if (m_rx !== 8'hAA) $display("FAIL rd_data: rx_data=%h want aa", m_rx); else passes++;
        repeat (2) @(negedge clk);
        checks++; if (rise_bits[7:0] !== 8'h0F) $display("FAIL rd_cmd_bits: %h want 0f", rise_bits[7:0]); else passes++;
        checks++; if (rise_cnt !== 16) $display("FAIL rd_rise_count: %0d want 16", rise_cnt); else passes++;
        checks++; if (ctl1 !== 34) $display("FAIL rd_drive_cycles: %0d cycles with control=1 want 34", ctl1); else passes++;
    endtask

    task automatic test_start_ignored();
        int c;
        int gaps;
        launch(1'b0, 1'b0, 8'h5A, 8'h81, 8'h00);
        c = 0;
        gaps = 0;
        while (!m_done && c < 400) begin
            if (c == 10) start2 = 1'b1;
            if (c == 11) start2 = 1'b0;
            @(negedge clk);
            c++;
            if (!m_busy) gaps++;
        end
        if (!m_done) c = -1;
        checks++; if (c !== 68) $display("FAIL ign_mid_latency: done after %0d clocks want 68", c); else passes++;
        checks++; if (gaps !== 0) $display("FAIL ign_busy_gap: %0d cycles busy=0 want 0", gaps); else passes++;
        // Hold start through DONE: the DONE-cycle sample must be ignored.
        start2 = 1'b1;
        @(negedge clk);
        checks++; if ({m_busy, m_cs_n} !== 2'b01) $display("FAIL ign_done_start: busy,cs_n=%b want 01", {m_busy, m_cs_n}); else passes++;
        @(negedge clk);
        start2 = 1'b0;
        checks++; if ({m_busy, m_cs_n} !== 2'b10) $display("FAIL ign_idle_accept: busy,cs_n=%b want 10", {m_busy, m_cs_n}); else passes++;
        run_to_done(c);
        checks++; if (c !== 68) $display("FAIL ign_second_latency: done after %0d clocks want 68", c); else passes++;
        repeat (2) @(negedge clk);
        checks++; if (rise_bits[15:0] !== 16'h815A) $display("FAIL ign_second_bits: %h want 815a", rise_bits[15:0]); else passes++;
        checks++; if (m_rx !== 8'hAA) $display("FAIL ign_rx_held: rx_data=%h want aa", m_rx); else passes++;
    endtask

    task automatic test_reset_mid_read();
        int w;
        int dones;
        launch(1'b0, 1'b1, 8'hC3, 8'h00, 8'h55);
        w = 0;
        while (fall_cnt < 12 && w < 400) begin
            @(negedge clk);
            w++;
        end
        checks++; if (w >= 400) $display("FAIL rst_reach_rx4: timed out after %0d clocks want < 400", w); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if ({m_cs_n, m_control, m_sclk} !== 3'b100) $display("FAIL rst_mid_pins: cs_n,control,sclk=%b want 100", {m_cs_n, m_control, m_sclk}); else passes++;
        checks++; if (m_rx !== 8'h00) $display("FAIL rst_mid_rx: rx_data=%h want 00", m_rx); else passes++;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_done) dones++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (m_done) dones++;
        end
        checks++; if (dones !== 0) $display("FAIL rst_no_done: %0d done pulses want 0", dones); else passes++;
        checks++; if (m_busy !== 1'b0) $display("FAIL rst_busy: busy=%b want 0", m_busy); else passes++;
    endtask

    task automatic test_read_after_reset();
        int c;
        launch(1'b0, 1'b1, 8'h96, 8'h00, 8'h3C);
        run_to_done(c);
        checks++; if (c !== 70) $display("FAIL rar_latency: done after %0d clocks want 70", c); else passes++;
        checks++; if (m_rx !== 8'h3C) $display("FAIL rar_data: rx_data=%h want 3c", m_rx); else passes++;
        repeat (2) @(negedge clk);
        checks++; if (rise_bits[7:0] !== 8'h96) $display("FAIL rar_cmd_bits: %h want 96", rise_bits[7:0]); else passes++;
    endtask

    task automatic test_clkdiv1();
        int c;
        int bad;
        launch(1'b1, 1'b0, 8'hFF, 8'h00, 8'h00);
        c = 0;
        bad = 0;
        while (!m_done && c < 200) begin
            if (c >= 1 && c <= 32 && m_sclk !== 1'((c % 2) == 0)) bad++;
            @(negedge clk);
            c++;
        end
        if (!m_done) c = -1;
        checks++; if (c !== 34) $display("FAIL div1_latency: done after %0d clocks want 34", c); else passes++;
        checks++; if (bad !== 0) $display("FAIL div1_sclk_toggle: %0d wrong sclk cycles want 0", bad); else passes++;
        repeat (2) @(negedge clk);
        checks++; if (rise_bits[15:0] !== 16'h00FF) $display("FAIL div1_bits: %h want 00ff", rise_bits[15:0]); else passes++;
        checks++; if (rise_cnt !== 16) $display("FAIL div1_rise_count: %0d want 16", rise_cnt); else passes++;
        sel = 1'b0;
    endtask

    task automatic test_bus_rules();
        checks++; if (mon_errs !== 0) $display("FAIL bus_rules: %0d monitor violations want 0", mon_errs); else passes++;
    endtask

    initial begin
        sel      = 1'b0;
        rst_n    = 1'b0;
        start2   = 1'b0;
        start1   = 1'b0;
        rw       = 1'b0;
        cmd_data = '0;
        wr_data  = '0;
        test_reset();
        test_write();
        test_read();
        test_start_ignored();
        test_reset_mid_read();
        test_read_after_reset();
        test_clkdiv1();
        test_bus_rules();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/spi3w_master_shifter.md
Name: spi3w_master_shifter

Overview:
- Half-duplex 3-wire SPI master byte engine, directly upstream of the inout_port tristate cell.
- Drives the cell's outline and control inputs and consumes its inline output; the cell's portline is the shared SDIO pin.
- Each transaction sends one command byte, then either writes one data byte or turns the bus around and reads one byte.
- Generates sclk and cs_n for the slave.

Parameters:
- CLK_DIV, 4: system clocks per sclk half-period; legal range 1..255.
- DATA_W, 8: bits per byte phase; fixed at 8 for this release.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  transaction request; sampled only in IDLE.
- rw  in  1  0 = write (cmd + wr_data), 1 = read (cmd + receive); captured with start.
- cmd_data  in  8  command byte; captured with start.
- wr_data  in  8  write payload; captured with start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse at end of transaction.
- rx_data  out  8  received byte; updated in the DONE cycle of reads only, held otherwise.
- sclk  out  1  serial clock, SPI mode 0 (idle low).
- cs_n  out  1  slave select, active low.
- outline  out  1  serial data to inout_port.
- control  out  1  to inout_port: 1 = drive portline, 0 = release/receive.
- inline  in  1  serial data from inout_port.

Behaviour:
- Reset (async assert, sync release): state IDLE, cs_n=1, sclk=0, control=0, outline=0, busy=0, done=0, rx_data=0, counters 0.
- Half-period tick: divider counts CLK_DIV clocks. Tick pulses on the last clock of each half-period. Divider is cleared in IDLE.
- Bit order is LSB first. Each bit is a low half followed by a high half.
  - outline is updated at the start of the low half.
  - inline is sampled on the tick that ends the low half, i.e. the sclk rising edge.
  - sclk falls at the end of the high half.
- IDLE: if start=1, capture rw/cmd_data/wr_data and go to SETUP. start is ignored in every other state.
- SETUP: 1 half-period. cs_n=0, control=1, sclk=0, outline=cmd_data[0].
- TX_CMD: 8 bits of cmd_data.
  - Then TX_DATA if rw=0.
  - Then TURN if rw=1.
- TX_DATA: 8 bits of wr_data, control=1, then HOLD.
- TURN: 1 half-period. control=0, outline=0, sclk=0. No edge is generated.
- RX_DATA: 8 bits, control=0. Bit i is shifted into rx shift register position i on sclk rise i. Then HOLD.
- HOLD: 1 half-period with sclk=0 and cs_n=0. control keeps its previous value (1 for write, 0 for read).
- DONE: 1 clock.
  - cs_n=1, control=0, done=1.
  - rx_data loads the shift register if rw=1.
  - Then IDLE.
- Latency, with start accepted on edge k:
  - Write: done is high in cycle k + 34*CLK_DIV + 1.
  - Read: done is high in cycle k + 35*CLK_DIV + 1.
- Bus-contention rule: control never rises while cs_n=0 after a TURN. control is 0 in every cycle where the slave may drive.
- Reset mid-transaction: all outputs return to reset values immediately. No done pulse. rx_data is cleared.
- CLK_DIV=1: each half-period is one clock. Sampling still occurs on the low-to-high transition.
- Back-to-back: start held high during DONE is not accepted until the following IDLE cycle. This gives at least 1 idle clock with cs_n=1 between transactions.

Decomposition:
- Package spi_pkg holds:
  - state encoding: IDLE, SETUP, TX_CMD, TX_DATA, TURN, RX_DATA, HOLD, DONE;
  - DATA_W;
  - localparam DIV_W=8 for the divider counter;
  - the constants CTRL_DRIVE=1 and CTRL_RELEASE=0.
- One sub-module, spi_half_tick: parameterised CLK_DIV counter with enable/clear, outputting a one-clock tick.
- The bit counter and shift registers stay in the top module.

Test Plan:
- Write, CLK_DIV=2, cmd=0xA5, wr=0x3C → outline at successive sclk rises is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. control=1 throughout cs_n low. done at cycle k+69. Exactly 16 sclk rises.
- Read, CLK_DIV=2, cmd=0x0F, slave model drives 0xAA LSB-first on inline while control=0 → outline bits 1,1,1,1,0,0,0,0. control=0 from TURN to DONE. rx_data=0xAA at done, cycle k+71.
- start pulsed again at mid-transaction and in the DONE cycle → ignored. Second transaction begins only after start is seen in IDLE. busy stays continuous.
- rst_n asserted during RX bit 4 of a read → cs_n=1, control=0, sclk=0 immediately. No done pulse. rx_data=0. A new read after release returns correct data.
- CLK_DIV=1, write cmd=0xFF, wr=0x00 → sclk toggles every clock. done at k+35. Outline pattern is correct.
- Checker over all tests: no cycle has control=1 while the slave model is driving. sclk=0 whenever cs_n=1.
